// File: rtl/enable_seq_pkg.sv
// Shared types and defaults for the frame-based enable sequencer.
// Imported by the interface, the window comparator and the top level.
package enable_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  localparam int NUM_EN_DEF = 10;
  localparam int CNT_W_DEF  = 4;

endpackage

// File: rtl/enable_sequencer_if.sv
// Control/status bundle between the control FSM and the enable sequencer.
// The master drives the configuration and start/stop; the slave returns enables.
interface enable_sequencer_if
  import enable_seq_pkg::*;
#(
  parameter int NUM_EN = NUM_EN_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic                    start_i;
  logic                    stop_i;
  logic                    mode_i;
  logic [CNT_W-1:0]        period_i;
  logic [NUM_EN*CNT_W-1:0] slot_start_i;
  logic [NUM_EN*CNT_W-1:0] slot_len_i;
  logic [NUM_EN-1:0]       enable_o;
  logic                    frame_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    output start_i, stop_i, mode_i,
    output period_i, slot_start_i, slot_len_i,
    input  enable_o, frame_o, busy_o, done_o
  );

  modport slave (
    input  start_i, stop_i, mode_i,
    input  period_i, slot_start_i, slot_len_i,
    output enable_o, frame_o, busy_o, done_o
  );

endinterface

// File: rtl/enable_window_cmp.sv
// Per-channel window test: start <= cnt < start+len.
// End is formed one bit wider so windows never wrap past the frame.
module enable_window_cmp #(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] start,
  input  logic [CNT_W-1:0] len,
  output logic             in_window
);

  logic [CNT_W:0] c_ext;
  logic [CNT_W:0] s_ext;
  logic [CNT_W:0] e_ext;

  assign c_ext = {1'b0, cnt};
  assign s_ext = {1'b0, start};
  assign e_ext = {1'b0, start} + {1'b0, len};

  assign in_window = (c_ext >= s_ext) && (c_ext < e_ext);

endmodule

// File: rtl/enable_sequencer.sv
// Frame counter, IDLE/RUN control and registered enable/status outputs.
// Configuration is shadowed on start so the bus may change during a run.
module enable_sequencer
  import enable_seq_pkg::*;
#(
  parameter int NUM_EN = NUM_EN_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic               clk_i,
  input logic               reset_i,
  enable_sequencer_if.slave bus
);

  state_e                  state;
  state_e                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    stop_q;
  logic                    stop_nxt;
  logic                    load;
  logic                    last;
  logic                    mode_q;
  logic [CNT_W-1:0]        per_q;
  logic [NUM_EN*CNT_W-1:0] st_q;
  logic [NUM_EN*CNT_W-1:0] ln_q;
  logic [NUM_EN-1:0]       win;
  logic [NUM_EN-1:0]       en_q;
  logic                    frame_q;
  logic                    busy_q;
  logic                    done_q;

  for (genvar k = 0; k < NUM_EN; k++) begin : g_ch
    enable_window_cmp #(
      .CNT_W (CNT_W)
    ) u_cmp (
      .cnt       (cnt),
      .start     (st_q[k*CNT_W +: CNT_W]),
      .len       (ln_q[k*CNT_W +: CNT_W]),
      .in_window (win[k])
    );
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stop_nxt  = stop_q;
    load      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          stop_nxt  = 1'b0;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop_i) stop_nxt = 1'b1;
        if (cnt == per_q) begin
          cnt_nxt = '0;
          // a stop seen on the final slot still ends this frame
          if (mode_q == MODE_ONESHOT ||
              stop_q || bus.stop_i) begin
            last      = 1'b1;
            state_nxt = IDLE;
            stop_nxt  = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      cnt     <= '0;
      stop_q  <= 1'b0;
      en_q    <= '0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      stop_q  <= stop_nxt;
      en_q    <= (state == RUN) ? win : '0;
      frame_q <= (state == RUN) && (cnt == '0);
      busy_q  <= (state_nxt == RUN);
      done_q  <= last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (load) begin
      mode_q <= bus.mode_i;
      per_q  <= bus.period_i;
      st_q   <= bus.slot_start_i;
      ln_q   <= bus.slot_len_i;
    end
  end

  assign bus.enable_o = en_q;
  assign bus.frame_o  = frame_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;

endmodule
